// File: rtl/selftrig_pkg.sv
// Shared types and helpers for the self-trigger arbiter: FSM state encoding,
// drop-counter width and a saturating adder for the drop counter.
package selftrig_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam int DROP_W     = 16;
    // Wide enough to count drops from up to 16 channels in a single cycle.
    localparam int DROP_INC_W = 5;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [DROP_INC_W-1:0] b);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + {{(DROP_W - DROP_INC_W + 1){1'b0}}, b};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: returns the first set request bit found
// when scanning upward from ptr and wrapping from NCH-1 back to 0.
module rr_pick #(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic                   found,
    output logic [$clog2(NCH)-1:0] idx
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0] rot;
    logic [CW-1:0]  cand [NCH];

    // rot[gi] is the request sitting gi positions after the pointer.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
        logic [CW:0] sum;
        assign sum       = {1'b0, ptr} + (CW+1)'(gi);
        assign cand[gi]  = (sum >= (CW+1)'(NCH)) ? CW'(sum - (CW+1)'(NCH)) : sum[CW-1:0];
        assign rot[gi]   = req[cand[gi]];
    end

    always_comb begin
        found = |rot;
        idx   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                idx = cand[j];
            end
        end
    end

endmodule

// File: rtl/selftrigger_arbiter.sv
// Round-robin arbiter granting self-trigger channels to one shared readout engine.
// Optional macro SELFTRIG_TIMESTAMP_EN adds per-trigger timestamps on rd_ts.
module selftrigger_arbiter
    import selftrig_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int HOLDOFF = 256
`ifdef SELFTRIG_TIMESTAMP_EN
    , parameter int TS_W  = 64
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NCH-1:0]         ch_mask,
    input  logic [NCH-1:0]         trig_in,
    output logic                   rd_valid,
    output logic [$clog2(NCH)-1:0] rd_ch,
`ifdef SELFTRIG_TIMESTAMP_EN
    output logic [TS_W-1:0]        rd_ts,
`endif
    input  logic                   rd_ready,
    input  logic                   rd_done,
    output logic                   busy,
    output logic [NCH-1:0]         pending,
    output logic [DROP_W-1:0]      drop_cnt
);
    localparam int CW = $clog2(NCH);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

    state_t                  state_reg, state_next;
    logic [NCH-1:0]          trig_d_reg, pending_reg, pending_next;
    logic [CW-1:0]           rr_ptr_reg, rr_ptr_next, rd_ch_reg, rd_ch_next;
    logic [DROP_W-1:0]       drop_cnt_reg;
    logic                    pick_found, accept;
    logic [CW-1:0]           pick_idx;
    logic [NCH-1:0]          clear_vec, latch_vec, drop_vec;
    logic [DROP_INC_W-1:0]   drop_num;
`ifdef SELFTRIG_TIMESTAMP_EN
    logic [TS_W-1:0]          ts_cnt_reg, rd_ts_reg;
    logic [NCH-1:0][TS_W-1:0] ts_vec;
`endif

    rr_pick #(.NCH(NCH)) u_pick (
        .req   (pending_reg),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign accept = (state_reg == GRANT) && rd_ready;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic          trig_edge, hold_busy;
        logic [HW-1:0] holdoff_reg;

        assign trig_edge      = trig_in[gi] & ~trig_d_reg[gi] & enable & ch_mask[gi];
        assign clear_vec[gi]  = accept && (rd_ch_reg == CW'(gi));
        // The holdoff loaded by this cycle's acceptance already blocks a new edge.
        assign hold_busy      = (holdoff_reg != '0) || (clear_vec[gi] && (HOLDOFF > 0));
        assign latch_vec[gi]  = trig_edge & ~hold_busy & ~(pending_reg[gi] & ~clear_vec[gi]);
        assign drop_vec[gi]   = trig_edge & ~latch_vec[gi];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                holdoff_reg <= '0;
            end else if (clear_vec[gi]) begin
                holdoff_reg <= HOLD_LOAD;
            end else if (holdoff_reg != '0) begin
                holdoff_reg <= holdoff_reg - 1'b1;
            end
        end

`ifdef SELFTRIG_TIMESTAMP_EN
        logic [TS_W-1:0] ts_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ts_reg <= '0;
            end else if (latch_vec[gi]) begin
                ts_reg <= ts_cnt_reg;
            end
        end
        assign ts_vec[gi] = ts_reg;
`endif
    end

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NCH; i++) begin
            drop_num = drop_num + DROP_INC_W'(drop_vec[i]);
        end
    end

    assign pending_next = (pending_reg & ~clear_vec) | latch_vec;

    always_comb begin
        state_next  = state_reg;
        rd_ch_next  = rd_ch_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    rd_ch_next = pick_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (rd_ready) begin
                    rr_ptr_next = (rd_ch_reg == CW'(NCH - 1)) ? '0 : rd_ch_reg + 1'b1;
                    state_next  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rd_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            trig_d_reg   <= '0;
            pending_reg  <= '0;
            rr_ptr_reg   <= '0;
            rd_ch_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            trig_d_reg  <= trig_in;
            pending_reg <= pending_next;
            rr_ptr_reg  <= rr_ptr_next;
            rd_ch_reg   <= rd_ch_next;
            if (|drop_vec) begin
                drop_cnt_reg <= sat_add(drop_cnt_reg, drop_num);
            end
        end
    end

`ifdef SELFTRIG_TIMESTAMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_reg <= '0;
            rd_ts_reg  <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 1'b1;
            if (state_reg == IDLE && pick_found) begin
                rd_ts_reg <= ts_vec[pick_idx];
            end
        end
    end
    assign rd_ts = rd_ts_reg;
`endif

    assign rd_valid = (state_reg == GRANT);
    assign busy     = (state_reg != IDLE);
    assign rd_ch    = rd_ch_reg;
    assign pending  = pending_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_selftrigger_arbiter.sv
// Scoreboard bench for selftrigger_arbiter: a cycle-stepped behavioural model
// predicts grants (queued) and status; a negedge monitor compares the DUT.
module tb_selftrigger_arbiter;
    localparam int NCH     = 8;
    localparam int HOLDOFF = 4;
    localparam int CW      = $clog2(NCH);
    localparam int TS_W    = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic           rd_ready = 1'b0;
    logic           rd_done = 1'b0;
    logic [NCH-1:0] ch_mask = '1;
    logic [NCH-1:0] trig_in = '0;
    logic           rd_valid, busy;
    logic [CW-1:0]  rd_ch;
    logic [NCH-1:0] pending;
    logic [15:0]    drop_cnt;
`ifdef SELFTRIG_TIMESTAMP_EN
    logic [TS_W-1:0] rd_ts;
`endif

    always #5 clk = ~clk;

    selftrigger_arbiter #(
        .NCH(NCH),
        .HOLDOFF(HOLDOFF)
`ifdef SELFTRIG_TIMESTAMP_EN
        , .TS_W(TS_W)
`endif
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .trig_in(trig_in),
        .rd_valid(rd_valid), .rd_ch(rd_ch),
`ifdef SELFTRIG_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .rd_ready(rd_ready), .rd_done(rd_done), .busy(busy),
        .pending(pending), .drop_cnt(drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 = arbiter free, 1 = grant offered, 2 = record in progress
    int             m_phase, m_offer, m_ptr, m_drops;
    bit [NCH-1:0]   m_pend, m_prev;
    longint         m_cyc;
    longint         m_last_acc [NCH];
    int             exp_q [$];
    longint         m_tsc;
    longint         m_ts [NCH];
    longint         exp_ts_q [$];

    always @(posedge clk or posedge reset) begin
        int           acc;
        bit           found, blocked, busy_old;
        bit [NCH-1:0] new_set;
        if (reset) begin
            m_phase = 0; m_offer = 0; m_ptr = 0; m_drops = 0;
            m_pend = '0; m_prev = '0; m_cyc = 0; m_tsc = 0;
            for (int i = 0; i < NCH; i++) begin
                m_last_acc[i] = -1000;
                m_ts[i] = 0;
            end
            exp_q.delete();
            exp_ts_q.delete();
        end else begin
            acc = -1;
            if (m_phase == 0) begin
                found = 0;
                for (int j = 0; j < NCH; j++) begin
                    if (!found && m_pend[(m_ptr + j) % NCH]) begin
                        found = 1;
                        m_offer = (m_ptr + j) % NCH;
                    end
                end
                if (found) begin
                    m_phase = 1;
                    exp_q.push_back(m_offer);
                    exp_ts_q.push_back(m_ts[m_offer]);
                end
            end else if (m_phase == 1) begin
                if (rd_ready) begin
                    acc = m_offer;
                    m_phase = 2;
                end
            end else if (rd_done) begin
                m_phase = 0;
            end
            new_set = '0;
            for (int i = 0; i < NCH; i++) begin
                if (trig_in[i] && !m_prev[i] && enable && ch_mask[i]) begin
                    blocked  = (HOLDOFF > 0) && ((i == acc) || (m_cyc - m_last_acc[i] <= HOLDOFF));
                    busy_old = m_pend[i] && (i != acc);
                    if (blocked || busy_old) begin
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        new_set[i] = 1'b1;
                        m_ts[i] = m_tsc;
                    end
                end
            end
            if (acc >= 0) begin
                m_pend[acc]     = 1'b0;
                m_last_acc[acc] = m_cyc;
                m_ptr           = (acc + 1) % NCH;
            end
            m_pend = m_pend | new_set;
            m_prev = trig_in;
            m_cyc++;
            m_tsc++;
        end
    end

    // ---------------- monitor ----------------
    bit     mon_prev = 0;
    int     cur_exp = 0;
    longint cur_exp_ts = 0;
    int     acc_log [$];

    always @(negedge clk) begin
        check("rd_valid", rd_valid, longint'(m_phase == 1));
        check("busy", busy, longint'(m_phase != 0));
        check("pending", pending, m_pend);
        check("drop_cnt", drop_cnt, m_drops);
        if (rd_valid && !mon_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL grant_unexpected: got rd_ch=%0d, expected no grant (t=%0t)", rd_ch, $time);
            end else begin
                cur_exp    = exp_q.pop_front();
                cur_exp_ts = exp_ts_q.pop_front();
            end
        end
        if (rd_valid) begin
            check("rd_ch", rd_ch, cur_exp);
`ifdef SELFTRIG_TIMESTAMP_EN
            check("rd_ts", rd_ts, cur_exp_ts);
`endif
        end
        if (rd_valid && rd_ready) begin
            acc_log.push_back(int'(rd_ch));
            $display("[TB] grant accepted ch=%0d t=%0t", rd_ch, $time);
        end
        mon_prev = rd_valid;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_trig(input logic [NCH-1:0] v);
        trig_in = v;
        tick(1);
        trig_in = '0;
    endtask

    task automatic pulse_done();
        rd_done = 1'b1;
        tick(1);
        rd_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trig_in = '0;
        rd_done = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        acc_log.delete();
    endtask

    initial begin
        int rr_exp [4];
        rr_exp[0] = 1; rr_exp[1] = 5; rr_exp[2] = 6; rr_exp[3] = 1;

        tick(3);
        reset = 1'b0;
        enable = 1'b1;
        rd_ready = 1'b1;
        tick(2);

        // single trigger on ch3
        pulse_trig(8'h08);
        tick(6);
        pulse_done();
        tick(4);

        // simultaneous ch1/ch5/ch6, then ch1 again after the pointer reaches 7
        do_reset();
        rd_ready = 1'b1;
        pulse_trig(8'h62);
        repeat (8) begin
            tick(2);
            pulse_done();
        end
        pulse_trig(8'h02);
        repeat (4) begin
            tick(2);
            pulse_done();
        end
        check("rr_count", acc_log.size(), 4);
        for (int k = 0; k < 4 && k < acc_log.size(); k++) begin
            check($sformatf("rr_order_%0d", k), acc_log[k], rr_exp[k]);
        end

        // drop on a pending channel and during holdoff
        do_reset();
        rd_ready = 1'b0;
        pulse_trig(8'h04);
        tick(1);
        pulse_trig(8'h04);
        rd_ready = 1'b1;
        tick(2);
        pulse_trig(8'h04);
        pulse_done();
        tick(10);
        check("drop_directed", drop_cnt, 2);
        check("drop_grants", acc_log.size(), 1);

        // readout engine stalls for 10 cycles with stray done pulses
        do_reset();
        rd_ready = 1'b0;
        pulse_trig(8'h10);
        tick(1);
        for (int k = 0; k < 10; k++) begin
            rd_done = (k % 3 == 1);
            tick(1);
        end
        rd_done = 1'b0;
        rd_ready = 1'b1;
        tick(1);
        pulse_done();
        tick(3);

        // disabled edges ignored; reset while a record is in progress
        do_reset();
        rd_ready = 1'b0;
        pulse_trig(8'h04);
        tick(1);
        enable = 1'b0;
        pulse_trig(8'h11);
        tick(2);
        enable = 1'b1;
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_rd_ch", rd_ch, 0);
        check("en_grants", acc_log.size(), 1);
        if (acc_log.size() > 0) check("en_grant_ch", acc_log[0], 2);
        reset = 1'b0;
        tick(2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            trig_in  = NCH'($urandom & $urandom & $urandom);
            enable   = ($urandom_range(0, 15) != 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            rd_done  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) ch_mask = NCH'($urandom | $urandom);
            tick(1);
        end

        // drain
        trig_in = '0;
        rd_ready = 1'b1;
        ch_mask = '1;
        repeat (30) begin
            tick(1);
            pulse_done();
        end
        check("scoreboard_empty", exp_q.size(), 0);
        check("drain_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
